bit_stream_serializer: RTL and testbench

//  Parallel-in/serial-out word serializer; upstream stage feeding the serial 'signal' input of the
//  FSM sequence detectors. Accepts a WIDTH-bit word via valid/ready, shifts it out MSB-first at one
//  bit per clk, supports gap-free back-to-back words, drives IDLE_LVL on 'signal' when idle.

---
 rtl/ser_pkg.sv | 18 +
 rtl/bit_stream_serializer_piso_shreg.sv | 28 ++
 rtl/bit_stream_serializer.sv | 111 +++++++++++
 tb/tb_bit_stream_serializer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the bit-stream serializer: FSM state encodings,
// default idle level and the bit-counter width helper.
package ser_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   localparam logic IDLE_LVL_DEF = 1'b0;

   // Counter must be able to hold WIDTH (one past the last data bit index).
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_stream_serializer_piso_shreg.sv
// WIDTH-bit load/shift-left register; o_next is the bit that becomes MSB after
// the next shift. Async active-low reset.
module piso_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_next
);

   logic [WIDTH-1:0] r_q;

   // Departing MSB wraps to the LSB; it is never observed again within a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_q <= '0;
      else if (i_load)
         r_q <= i_d;
      else if (i_shift)
         r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
   end

   assign o_next = r_q[WIDTH-2];

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-in/serial-out word serializer, MSB first, gap-free back-to-back.
// Optional even-parity bit after the LSB when SER_PARITY_EN is defined.
module bit_stream_serializer
   import ser_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             signal,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_bit_cnt;
   logic          r_signal, r_busy;
   logic          w_next_bit, w_last_data, w_final, w_accept, w_shift;

   assign w_last_data = (r_state == S_SHIFT) && (r_bit_cnt == LAST);
`ifdef SER_PARITY_EN
   assign w_final     = (r_state == S_PARITY);
`else
   assign w_final     = w_last_data;
`endif
   assign load_ready  = (r_state == S_IDLE) || w_final;
   assign w_accept    = load_valid & load_ready;
   assign w_shift     = (r_state == S_SHIFT) && !w_last_data;

   assign signal = r_signal;
   assign busy   = r_busy;
   assign done   = w_final;

   piso_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_accept),
      .i_shift (w_shift),
      .i_d     (data_in),
      .o_next  (w_next_bit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_SHIFT;
         S_SHIFT:  if (w_last_data) begin
`ifdef SER_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
`endif
         end
         S_PARITY: w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

`ifdef SER_PARITY_EN
   logic r_par;

   // Running XOR of every data bit already placed on 'signal'.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_par <= 1'b0;
      else if (w_accept)
         r_par <= data_in[WIDTH-1];
      else if (w_shift)
         r_par <= r_par ^ w_next_bit;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_signal  <= IDLE_LVL;
         r_busy    <= 1'b0;
         r_bit_cnt <= '0;
      end else if (w_accept) begin
         r_signal  <= data_in[WIDTH-1];
         r_busy    <= 1'b1;
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         r_signal  <= w_next_bit;
         r_bit_cnt <= r_bit_cnt + CW'(1);
`ifdef SER_PARITY_EN
      end else if (w_last_data) begin
         r_signal  <= r_par;
         r_bit_cnt <= r_bit_cnt + CW'(1);
`endif
      end else if (w_final) begin
         r_signal  <= IDLE_LVL;
         r_busy    <= 1'b0;
         r_bit_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: stimulus queues expected bits on
// accept, a negedge monitor pops and compares. Honors SER_PARITY_EN.
module tb_bit_stream_serializer;

   localparam int W = 8;

   typedef struct packed {
      logic sig;
      logic dn;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         load_valid = 1'b0;
   logic         load_ready, signal, busy, done;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   bit_stream_serializer #(.WIDTH(W), .IDLE_LVL(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .signal     (signal),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_word(input logic [W-1:0] d);
      bit par_en = 1'b0;
`ifdef SER_PARITY_EN
      par_en = 1'b1;
`endif
      for (int i = W - 1; i >= 0; i--)
         q.push_back('{sig: d[i], dn: (i == 0) && !par_en});
      if (par_en)
         q.push_back('{sig: ^d, dn: 1'b1});
   endfunction

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic send_word(input logic [W-1:0] d, input bit hold);
      int c = 0;
      data_in    = d;
      load_valid = 1'b1;
      while (!load_ready && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      if (!load_ready) chk("ready_timeout", 32'(load_ready), 32'd1);
      @(posedge clk); #1;
      push_word(d);
      if (!hold) load_valid = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      while (q.size() > 0 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("busy", 32'(busy), 32'd1);
            chk("signal", 32'(signal), 32'(e.sig));
            chk("done", 32'(done), 32'(e.dn));
         end else begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_signal", 32'(signal), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      // Reset held with a word offered: nothing may be captured.
      rst        = 1'b0;
      load_valid = 1'b1;
      data_in    = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_signal", 32'(signal), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      load_valid = 1'b0;
      rst        = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_no_capture", 32'(busy), 32'd0);

      // Single word.
      send_word(8'hA0, 1'b0);
      chk("mid_ready", 32'(load_ready), 32'd0);
      drain();

      // Back-to-back with valid held: contiguous bits, busy never drops.
      send_word(8'hA5, 1'b1);
      send_word(8'h5A, 1'b0);
      drain();

      // Valid pulse while not ready must be ignored.
      send_word(8'hA5, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      data_in    = 8'h3C;
      load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
      drain();

      // Reset after 3 bits of 8'hFF aborts the word immediately.
      send_word(8'hFF, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      #1;
      chk("abort_signal", 32'(signal), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      send_word(8'h81, 1'b0);
      drain();

      // Boundary patterns and the parity vector (parity bit only when enabled).
      send_word(8'h00, 1'b1);
      send_word(8'hFF, 1'b1);
      send_word(8'h07, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
